// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversal datapath.
package bitrev_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest word bit_reverse can handle; callers zero-extend into this width.
    localparam int BR_MAX_W = 64;

    // Reverses the low w bits of v; bits at or above w come back as zero.
    function automatic logic [BR_MAX_W-1:0] bit_reverse(input logic [BR_MAX_W-1:0] v,
                                                        input int unsigned w);
        logic [BR_MAX_W-1:0] r;
        r = {<<{v}};
        return r >> (BR_MAX_W - w);
    endfunction

endpackage

// File: rtl/pattern_mem.sv
// DEPTH x WIDTH pattern register file: async clear, one synchronous write port,
// one combinational read port (a same-cycle write is seen by the next read only).
module pattern_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pattern_source.sv
// Streams a programmed number of pattern words over valid/ready, one-shot or looping,
// optionally bit-reversed. All outputs are registered.
//
//   state | meaning
//   IDLE  | waiting for start; out_valid low
//   RUN   | presenting words; busy high until the final transfer
module pattern_source
    import bitrev_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              reverse,
    input  logic [ADDR_W:0]   len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic              loop_r;
    logic              rev_r;
    logic [ADDR_W:0]   len_r;
    logic              stop_pending;

    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   len_cur;
    logic [ADDR_W-1:0] next_addr;
    logic              next_last;
    logic [WIDTH-1:0]  rd_data;
    logic [BR_MAX_W-1:0] rev_full;
    logic [WIDTH-1:0]  fetch_word;
    logic              xfer;
    logic              end_run;

    pattern_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (next_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        len_eff = len;
        if (len == '0 || len > (ADDR_W+1)'(DEPTH)) begin
            len_eff = (ADDR_W+1)'(DEPTH);
        end
    end

    // While IDLE the fetch uses the start-time inputs, since they are latched on the same edge.
    assign len_cur   = (state == IDLE) ? len_eff : len_r;
    assign next_addr = (state == IDLE || out_last) ? '0 : out_addr + 1'b1;
    assign next_last = ({1'b0, next_addr} == len_cur - 1'b1);

    assign rev_full   = bit_reverse(BR_MAX_W'(rd_data), WIDTH);
    assign fetch_word = ((state == IDLE) ? reverse : rev_r) ? rev_full[WIDTH-1:0] : rd_data;

    assign xfer = out_valid & out_ready;
    // A stop arriving in the same cycle as a transfer ends the run with that transfer.
    assign end_run = xfer & (stop_pending | stop | (out_last & ~loop_r));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            loop_r       <= 1'b0;
            rev_r        <= 1'b0;
            len_r        <= '0;
            stop_pending <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_addr     <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        loop_r       <= loop;
                        rev_r        <= reverse;
                        len_r        <= len_eff;
                        stop_pending <= 1'b0;
                        out_valid    <= 1'b1;
                        out_data     <= fetch_word;
                        out_addr     <= next_addr;
                        out_last     <= next_last;
                    end
                end
                RUN: begin
                    if (end_run) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        out_valid    <= 1'b0;
                        out_last     <= 1'b0;
                        stop_pending <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        if (stop) begin
                            stop_pending <= 1'b1;
                        end
                        if (xfer) begin
                            out_data <= fetch_word;
                            out_addr <= next_addr;
                            out_last <= next_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_source.sv
// Self-checking bench for pattern_source against a word-sequence reference model.
module tb_pattern_source;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          start;
    logic          stop;
    logic          loop;
    logic          reverse;
    logic [AW:0]   len;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [7:0] mdl_mem [DEPTH];
    int n_chk;
    int n_pass;

    pattern_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .reverse   (reverse),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [7:0] exp_word(input int a, input bit rev);
        logic [7:0] w;
        logic [7:0] r;
        w = mdl_mem[a];
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return rev ? r : w;
    endfunction

    task automatic wr(input int a, input int d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d[7:0];
        mdl_mem[a] = d[7:0];
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // One run: words are expected in address order 0..L-1 (wrapping when looping);
    // stop is issued once stop_at transfers have completed, with ready low for that
    // cycle and three more. abort_addr returns early while the run is still active.
    task automatic run(input int len_in, input bit loop_in, input bit rev_in,
                       input int ready_pct, input int stop_at, input int abort_addr);
        int l, ea, xf, hold;
        bit stop_pend, ending;
        l = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
        ea = 0; xf = 0; hold = 0; stop_pend = 1'b0; ending = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; loop = loop_in; reverse = rev_in; len = len_in[AW:0];
        stop = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; loop = 1'b0; reverse = 1'b0; len = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (ending) begin
                chk("end_valid", 32'(out_valid), 32'd0);
                chk("end_busy", 32'(busy), 32'd0);
                chk("done_pulse", 32'(done), 32'd1);
                stop = 1'b0; out_ready = 1'b0;
                @(posedge clk); #1;
                chk("done_clear", 32'(done), 32'd0);
                return;
            end
            chk("valid", 32'(out_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("no_done", 32'(done), 32'd0);
            chk("addr", 32'(out_addr), 32'(ea));
            chk("data", 32'(out_data), 32'(exp_word(ea, rev_in)));
            chk("last", 32'(out_last), 32'(ea == l - 1));
            if (abort_addr == ea) return;
            stop = 1'b0;
            if (stop_at == xf && !stop_pend) begin
                stop = 1'b1; stop_pend = 1'b1; hold = 4;
            end
            if (hold > 0) begin
                out_ready = 1'b0; hold--;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            if (out_ready) begin
                xf++;
                if (stop_pend || (ea == l - 1 && !loop_in)) ending = 1'b1;
                else ea = (ea == l - 1) ? 0 : ea + 1;
            end
            @(posedge clk); #1;
        end
        chk("run_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int rl, sa;
        bit rlp;
        n_chk = 0; n_pass = 0;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0; reverse = 1'b0; len = '0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) wr(i, (i < 4) ? 8'h30 : 8'h31);
        run(0, 1'b0, 1'b0, 100, -1, -1);
        run(3, 1'b1, 1'b0, 100, 10, -1);
        wr(0, 8'h01);
        run(1, 1'b0, 1'b1, 100, -1, -1);
        run(0, 1'b0, 1'b0, 50, -1, -1);
        run(0, 1'b0, 1'b0, 100, 2, -1);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(255)));
            rl  = int'($urandom_range(15));
            rlp = 1'($urandom_range(1));
            if (rlp) sa = int'($urandom_range(20));
            else sa = ($urandom_range(1) == 1) ? -1 : int'($urandom_range(7));
            run(rl, rlp, 1'($urandom_range(1)), int'($urandom_range(30, 100)), sa, -1);
        end

        run(0, 1'b0, 1'b0, 100, -1, 5);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_addr", 32'(out_addr), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        run(0, 1'b0, 1'b0, 100, -1, -1);
        run(4, 1'b0, 1'b1, 70, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pattern_source.md
# pattern_source

Parametrised test-pattern word source for the bit-reversal datapath. It holds a writable DEPTH×WIDTH pattern memory and streams a programmed number of words over a valid/ready interface. Streaming runs in one-shot or loop mode, with optional bit-reversal applied on output. It sits at the head of the pipeline and feeds the reversal stage and the display logic.

## Interface
- WIDTH, 8, word width in bits (≥1)
- DEPTH, 8, pattern entries (≥2); ADDR_W = max(1, $clog2(DEPTH)) derived
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- wr_en  in  1  pattern memory write strobe
- wr_addr  in  ADDR_W  write address; values ≥ DEPTH ignored
- wr_data  in  WIDTH  write data
- start  in  1  begin a run (honoured in IDLE only)
- stop  in  1  request end of run (honoured in RUN only)
- loop  in  1  loop mode, sampled at start
- reverse  in  1  emit bit-reversed words, sampled at start
- len  in  ADDR_W+1  words per pass, sampled at start; 0 or >DEPTH means DEPTH
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_data  out  WIDTH  output word
- out_addr  out  ADDR_W  memory index of out_data
- out_last  out  1  out_data is the final word of a pass
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a run ends

## Operation
- Reset (async): memory cleared to 0; state IDLE; all outputs 0.
- States are IDLE and RUN.
- IDLE→RUN on start: latch loop, reverse, and effective length L; present entry 0.
- If start and stop are high in the same IDLE cycle, start wins.
- A transfer occurs when out_valid & out_ready.
- On transfer with out_last=0: present entry out_addr+1.
- On transfer with out_last=1 and loop=1: wrap and present entry 0. No done pulse.
- On transfer with out_last=1 and loop=0: go to IDLE, out_valid=0, done=1 for one cycle.
- stop in RUN sets stop_pending. The next transfer ends the run: IDLE, out_valid=0, done=1. This holds regardless of out_last.
- start in RUN is ignored.
- Valid stability: once out_valid=1, out_data, out_addr and out_last are held until a transfer.
- out_last = (out_addr == L−1).
- reverse=1: out_data[i] = mem[out_addr][WIDTH−1−i].
- Writes are accepted in any state. The presented (registered) word is unaffected by a write. Later fetches see the new value.
- A write and a fetch to the same address in the same cycle: the fetch sees the old value.
- Address and length arithmetic is unsigned with no overflow. The wrap is by compare to L−1, not modulo 2^ADDR_W.

## Timing
- start sampled at edge N: out_valid=1 with entry 0 after edge N. busy=1 from edge N.
- With out_ready held high: one word per cycle, no bubbles, including across a loop wrap.
- Final transfer at edge M: out_valid=0, busy=0 and done=1 after edge M; done=0 after edge M+1.
- Earliest new start accepted at edge M+1.
- Memory write at edge W is visible to fetches from edge W+1.
- All outputs are registered; no combinational path from out_ready to out_valid.

## Structure
- Shared package bitrev_pkg holds:
  - state enum {IDLE, RUN}
  - function bit_reverse(WIDTH-generic)
- One sub-module, pattern_mem:
  - DEPTH×WIDTH register file with async clear
  - one synchronous write port, one combinational read port
- pattern_source holds the FSM, address counter, output registers and stop_pending.

## Test plan
- Write 0x30,0x30,0x30,0x30,0x31,0x31,0x31,0x31 to entries 0–7; start with len=0, loop=0, ready=1 -> 8 consecutive transfers with those words, out_last on the 8th, done after the 8th.
- Same contents, len=3, loop=1 -> word sequence 0x30,0x30,0x30 repeating with no bubbles; out_last every 3rd word; no done pulse.
- reverse=1 with entry 0 = 0x01, len=1, loop=0 -> single word 0x80, out_last=1, done.
- Toggle out_ready randomly during a run -> data, addr and last held stable while valid & !ready; no loss or duplication of the word sequence.
- stop asserted mid-run at addr 2 while ready=0, ready raised 3 cycles later -> word 2 transfers, then out_valid=0 and done=1.
- Assert reset with out_valid=1 at addr 5 -> all outputs 0 immediately; memory reads 0; a new start streams zeros.
